// File: rtl/lgn_pkg.sv
// Shared constants and FSM encoding for the LGN classifier frame sender.
package lgn_pkg;

   localparam int INPUTS     = 256;
   localparam int BYTE_W     = 8;
   localparam int CATEGORIES = 10;
   localparam int IDX_W      = 4;
   localparam int VAL_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/lgn_byte_serializer.sv
// Parallel-load shift register that emits the frame MSB byte first, with a
// saturating byte counter flagging the final byte.
module lgn_byte_serializer
   import lgn_pkg::*;
#(
   parameter int NUM_BYTES = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_i,
   input  logic                        shift_i,
   input  logic [BYTE_W*NUM_BYTES-1:0] data_i,
   output logic [BYTE_W-1:0]           byte_o,
   output logic                        last_o
);

   localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int DAT_W = BYTE_W * NUM_BYTES;

   logic [DAT_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign last_o = (cnt_q == CNT_W'(NUM_BYTES - 1));
   assign byte_o = sr_q[DAT_W-1 -: BYTE_W];

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = data_i;
         cnt_d = '0;
      end else if (shift_i) begin
         sr_d = sr_q << BYTE_W;
         // Hold at the last index rather than wrapping.
         if (!last_o) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lgn_frame_sender.sv
// Streams a binarized frame byte-wise into the classifier, waits SETTLE_CYCLES,
// then captures and holds the result until handoff. LGN_SENDER_STATS_EN adds frame_count.
module lgn_frame_sender
   import lgn_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_BYTES     = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BYTE_W*NUM_BYTES-1:0] frame_data,
   input  logic                        frame_valid,
   output logic                        frame_ready,
   output logic [BYTE_W-1:0]           byte_out,
   output logic                        shift_hold,
   input  logic [IDX_W-1:0]            cls_index,
   input  logic [VAL_W-1:0]            cls_value,
   output logic [IDX_W-1:0]            res_index,
   output logic [VAL_W-1:0]            res_value,
   output logic                        res_err,
   output logic                        res_valid,
   input  logic                        res_ready
`ifdef LGN_SENDER_STATS_EN
   ,
   output logic [15:0]                 frame_count
`endif
);

   state_t             state_q, state_d;
   logic [3:0]         settle_q, settle_d;
   logic [IDX_W-1:0]   res_index_q;
   logic [VAL_W-1:0]   res_value_q;
   logic               res_err_q;
   logic               accept, in_send, last_byte, capture, handoff;
   logic [BYTE_W-1:0]  ser_byte;

   assign frame_ready = (state_q == ST_IDLE) && !rst;
   assign accept      = frame_valid && frame_ready;
   assign in_send     = (state_q == ST_SEND);
   assign capture     = (state_q == ST_SETTLE) && (settle_q == 4'(SETTLE_CYCLES - 1));
   assign handoff     = (state_q == ST_DONE) && res_ready;

   lgn_byte_serializer #(
      .NUM_BYTES (NUM_BYTES)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (in_send),
      .data_i  (frame_data),
      .byte_o  (ser_byte),
      .last_o  (last_byte)
   );

   assign byte_out   = in_send ? ser_byte : '0;
   assign shift_hold = !in_send;
   assign res_valid  = (state_q == ST_DONE);
   assign res_index  = res_index_q;
   assign res_value  = res_value_q;
   assign res_err    = res_err_q;

   always_comb begin
      state_d  = state_q;
      settle_d = '0;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_SEND;
         ST_SEND:   if (last_byte) state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (capture) state_d = ST_DONE;
            else         settle_d = settle_q + 4'd1;
         end
         ST_DONE:   if (handoff) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         settle_q    <= '0;
         res_index_q <= '0;
         res_value_q <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         if (capture) begin
            res_index_q <= cls_index;
            res_value_q <= cls_value;
            res_err_q   <= (cls_index > IDX_W'(CATEGORIES - 1));
         end
      end
   end

`ifdef LGN_SENDER_STATS_EN
   logic [15:0] frame_count_q;

   always_ff @(posedge clk) begin
      if (rst)          frame_count_q <= '0;
      else if (handoff) frame_count_q <= frame_count_q + 16'd1;
   end

   assign frame_count = frame_count_q;
`endif

endmodule
